// File: rtl/gemm_tiled_engine.sv
// Tiled M x N x K GeMM engine: walks A/B tiles in SRAM, accumulates K-deep dot
// products per output element and writes C tiles through a back-pressured buffer.

module gemm_pe #(
    parameter int InDataWidth  = 8,
    parameter int OutDataWidth = 32,
    parameter int K            = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sgn,
    input  logic                         vld,
    input  logic                         first,
    input  logic [InDataWidth*K-1:0]     a_row,
    input  logic [InDataWidth*K-1:0]     b_col,
    output logic [OutDataWidth-1:0]      acc_nxt
);
    localparam int EW = InDataWidth + 1;
    localparam int PW = 2 * EW;

    logic [OutDataWidth-1:0] acc;
    logic [OutDataWidth-1:0] sum;
    logic signed [EW-1:0]    ea;
    logic signed [EW-1:0]    eb;
    logic signed [PW-1:0]    prod;

    // Operands gain one extra bit so a single signed multiplier serves both modes.
    always_comb begin
        sum  = '0;
        ea   = '0;
        eb   = '0;
        prod = '0;
        for (int k = 0; k < K; k++) begin
            ea   = $signed({sgn & a_row[k*InDataWidth + InDataWidth-1], a_row[k*InDataWidth +: InDataWidth]});
            eb   = $signed({sgn & b_col[k*InDataWidth + InDataWidth-1], b_col[k*InDataWidth +: InDataWidth]});
            prod = ea * eb;
            sum  = sum + OutDataWidth'(prod);
        end
        acc_nxt = first ? sum : acc + sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (vld)
            acc <= acc_nxt;
    end
endmodule

module gemm_tiled_engine #(
    parameter int InDataWidth   = 8,
    parameter int OutDataWidth  = 32,
    parameter int AddrWidth     = 16,
    parameter int SizeAddrWidth = 8,
    parameter int M             = 4,
    parameter int N             = 4,
    parameter int K             = 4,
    parameter int ReadLatency   = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                signed_i,
    input  logic [SizeAddrWidth-1:0]            M_size_i,
    input  logic [SizeAddrWidth-1:0]            K_size_i,
    input  logic [SizeAddrWidth-1:0]            N_size_i,
    output logic [AddrWidth-1:0]                sram_a_addr_o,
    output logic [AddrWidth-1:0]                sram_b_addr_o,
    output logic                                sram_rd_en_o,
    input  logic [InDataWidth*M*K-1:0]          sram_a_rdata_i,
    input  logic [InDataWidth*K*N-1:0]          sram_b_rdata_i,
    output logic [AddrWidth-1:0]                sram_c_addr_o,
    output logic [OutDataWidth*M*N-1:0]         sram_c_wdata_o,
    output logic                                sram_c_we_o,
    input  logic                                sram_c_ready_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                error_o
);
    localparam int SW  = SizeAddrWidth;
    localparam int AW  = AddrWidth;
    localparam int RL  = ReadLatency;
    localparam int TOP = RL - 1;
    localparam int MSH = $clog2(M);
    localparam int NSH = $clog2(N);
    localparam int KSH = $clog2(K);
    localparam logic [SW-1:0] MMASK = SW'(M - 1);
    localparam logic [SW-1:0] NMASK = SW'(N - 1);
    localparam logic [SW-1:0] KMASK = SW'(K - 1);

    typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, FINISH} state_t;

    state_t state, state_nxt;

    logic [SW-1:0] m_size, k_size, n_size;
    logic          sgn, err;
    logic [SW-1:0] mt_num, kt_num, nt_num;
    logic [SW-1:0] mt, nt, kt;
    logic          size_bad;
    logic          last_k, last_n, last_m;
    logic          issue, hs, inflight;
    logic [2:0]    pending;
    logic [AW-1:0] a_addr, b_addr, c_addr;

    logic [TOP:0]         vld_pipe, first_pipe, last_pipe;
    logic [TOP:0][AW-1:0] caddr_pipe;
    logic                 arr, arr_first, arr_last;

    logic [M-1:0][N-1:0][OutDataWidth-1:0] acc_nxt;
    logic [M-1:0][N-1:0][OutDataWidth-1:0] c_data;
    logic                                  c_valid;
    logic [AW-1:0]                         c_addr_q;

    assign mt_num = m_size >> MSH;
    assign kt_num = k_size >> KSH;
    assign nt_num = n_size >> NSH;

    assign size_bad = (m_size == '0) || (k_size == '0) || (n_size == '0) ||
                      ((m_size & MMASK) != '0) || ((k_size & KMASK) != '0) ||
                      ((n_size & NMASK) != '0);

    assign last_k = (kt == kt_num - SW'(1));
    assign last_n = (nt == nt_num - SW'(1));
    assign last_m = (mt == mt_num - SW'(1));

    assign a_addr = AW'(mt) * AW'(kt_num) + AW'(kt);
    assign b_addr = AW'(kt) * AW'(nt_num) + AW'(nt);
    assign c_addr = AW'(mt) * AW'(nt_num) + AW'(nt);

    assign hs       = c_valid & sram_c_ready_i;
    assign inflight = |vld_pipe;
    assign arr       = vld_pipe[TOP];
    assign arr_first = first_pipe[TOP];
    assign arr_last  = last_pipe[TOP];

    // Buffer plus last beats still in flight; each one will claim the single C slot.
    always_comb begin
        pending = {2'b00, c_valid};
        for (int i = 0; i < RL; i++)
            pending = pending + {2'b00, vld_pipe[i] & last_pipe[i]};
    end

    assign issue = (state == RUN) &&
                   (!last_k || pending == 3'd0 || (pending == 3'd1 && hs));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (start_i) state_nxt = CHECK;
            CHECK:  state_nxt = size_bad ? FINISH : RUN;
            RUN:    if (issue && last_k && last_n && last_m) state_nxt = DRAIN;
            DRAIN:  if (!inflight && (!c_valid || hs)) state_nxt = FINISH;
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_size <= '0;
            k_size <= '0;
            n_size <= '0;
            sgn    <= 1'b0;
            err    <= 1'b0;
            mt     <= '0;
            nt     <= '0;
            kt     <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                m_size <= M_size_i;
                k_size <= K_size_i;
                n_size <= N_size_i;
                sgn    <= signed_i;
                err    <= 1'b0;
                mt     <= '0;
                nt     <= '0;
                kt     <= '0;
            end
            if (state == CHECK)
                err <= size_bad;
            // kt innermost, then nt, then mt
            if (issue) begin
                if (!last_k) begin
                    kt <= kt + SW'(1);
                end else begin
                    kt <= '0;
                    if (!last_n) begin
                        nt <= nt + SW'(1);
                    end else begin
                        nt <= '0;
                        mt <= mt + SW'(1);
                    end
                end
            end
        end
    end

    // Beat tracking: bit TOP marks the cycle the SRAM data for that strobe is valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
            caddr_pipe <= '0;
        end else begin
            vld_pipe[0]   <= issue;
            first_pipe[0] <= (kt == '0);
            last_pipe[0]  <= last_k;
            caddr_pipe[0] <= c_addr;
            for (int i = 1; i < RL; i++) begin
                vld_pipe[i]   <= vld_pipe[i-1];
                first_pipe[i] <= first_pipe[i-1];
                last_pipe[i]  <= last_pipe[i-1];
                caddr_pipe[i] <= caddr_pipe[i-1];
            end
        end
    end

    for (genvar gm = 0; gm < M; gm++) begin : g_row
        for (genvar gn = 0; gn < N; gn++) begin : g_col
            gemm_pe #(
                .InDataWidth (InDataWidth),
                .OutDataWidth(OutDataWidth),
                .K           (K)
            ) u_pe (
                .clk    (clk_i),
                .rst    (rst_i),
                .sgn    (sgn),
                .vld    (arr),
                .first  (arr_first),
                .a_row  (sram_a_rdata_i[gm*K*InDataWidth +: K*InDataWidth]),
                .b_col  (sram_b_rdata_i[gn*K*InDataWidth +: K*InDataWidth]),
                .acc_nxt(acc_nxt[gm][gn])
            );
        end
    end

    // A fill in the same cycle as a handshake keeps the buffer valid with new data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c_valid  <= 1'b0;
            c_data   <= '0;
            c_addr_q <= '0;
        end else if (arr && arr_last) begin
            c_valid  <= 1'b1;
            c_data   <= acc_nxt;
            c_addr_q <= caddr_pipe[TOP];
        end else if (hs) begin
            c_valid  <= 1'b0;
        end
    end

    assign sram_a_addr_o  = a_addr;
    assign sram_b_addr_o  = b_addr;
    assign sram_rd_en_o   = issue;
    assign sram_c_addr_o  = c_addr_q;
    assign sram_c_wdata_o = c_data;
    assign sram_c_we_o    = c_valid;
    assign busy_o         = (state == CHECK) || (state == RUN) || (state == DRAIN);
    assign done_o         = (state == FINISH);
    assign error_o        = (state == FINISH) && err;
endmodule

// File: tb/tb_gemm_tiled_engine.sv
// Directed bench for gemm_tiled_engine: one instance at read latency 1 and one
// at read latency 3 share stimulus; each has its own SRAM read model.

module tb_gemm_tiled_engine;
    localparam int IW = 8;
    localparam int OW = 32;
    localparam int AW = 16;
    localparam int SW = 8;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int K  = 4;
    localparam int AB = IW*M*K;
    localparam int CB = OW*M*N;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic sgn = 1'b0;
    logic c_ready = 1'b1;
    logic [SW-1:0] m_size = '0, k_size = '0, n_size = '0;

    logic [AW-1:0] a_addr1, b_addr1, c_addr1, a_addr3, b_addr3, c_addr3;
    logic          rd1, we1, busy1, done1, err1, rd3, we3, busy3, done3, err3;
    logic [AB-1:0] a_rd1, b_rd1, a_rd3, b_rd3;
    logic [CB-1:0] c_wd1, c_wd3;
    logic [AW-1:0] a3_s1, a3_s2, b3_s1, b3_s2;

    logic [AB-1:0] amem [16];
    logic [AB-1:0] bmem [16];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    logic [AW-1:0]   wa1[$], wa3[$];
    logic [CB-1:0]   wd1[$], wd3[$];
    logic [2*AW-1:0] rlog[$];
    int rd_n1, rd_n3, done_n1, done_n3, errd_n1, errd_n3, err_n1;
    int done_cyc1, wr_cyc1, last_iss, last_acc, max_out, stall_n, kt_exp;
    bit stable_bad, hold_v;
    logic [AW-1:0] hold_addr;
    logic [CB-1:0] hold_data;

    int exp_a[12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    int exp_b[12] = '{0, 2, 4, 1, 3, 5, 0, 2, 4, 1, 3, 5};

    gemm_tiled_engine #(.ReadLatency(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .signed_i(sgn),
        .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
        .sram_a_addr_o(a_addr1), .sram_b_addr_o(b_addr1), .sram_rd_en_o(rd1),
        .sram_a_rdata_i(a_rd1), .sram_b_rdata_i(b_rd1),
        .sram_c_addr_o(c_addr1), .sram_c_wdata_o(c_wd1), .sram_c_we_o(we1),
        .sram_c_ready_i(c_ready), .busy_o(busy1), .done_o(done1), .error_o(err1)
    );

    gemm_tiled_engine #(.ReadLatency(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .signed_i(sgn),
        .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
        .sram_a_addr_o(a_addr3), .sram_b_addr_o(b_addr3), .sram_rd_en_o(rd3),
        .sram_a_rdata_i(a_rd3), .sram_b_rdata_i(b_rd3),
        .sram_c_addr_o(c_addr3), .sram_c_wdata_o(c_wd3), .sram_c_we_o(we3),
        .sram_c_ready_i(c_ready), .busy_o(busy3), .done_o(done3), .error_o(err3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd1) begin
            a_rd1 <= amem[a_addr1[3:0]];
            b_rd1 <= bmem[b_addr1[3:0]];
        end
    end

    always @(posedge clk) begin
        a3_s1 <= a_addr3;
        a3_s2 <= a3_s1;
        b3_s1 <= b_addr3;
        b3_s2 <= b3_s1;
        a_rd3 <= amem[a3_s2[3:0]];
        b_rd3 <= bmem[b3_s2[3:0]];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rd1) begin
                rlog.push_back({a_addr1, b_addr1});
                rd_n1++;
                if (kt_exp > 0 && rd_n1 % kt_exp == 0) last_iss++;
            end
            if (rd3) rd_n3++;
            if (we1 && c_ready) begin
                wa1.push_back(c_addr1);
                wd1.push_back(c_wd1);
                wr_cyc1 = cyc;
                last_acc++;
                hold_v = 1'b0;
            end
            if (we1 && !c_ready) begin
                stall_n++;
                if (hold_v && (c_addr1 !== hold_addr || c_wd1 !== hold_data)) stable_bad = 1'b1;
                hold_addr = c_addr1;
                hold_data = c_wd1;
                hold_v = 1'b1;
            end
            if (last_iss - last_acc > max_out) max_out = last_iss - last_acc;
            if (we3 && c_ready) begin
                wa3.push_back(c_addr3);
                wd3.push_back(c_wd3);
            end
            if (done1) begin done_n1++; done_cyc1 = cyc; end
            if (done3) done_n3++;
            if (err1) err_n1++;
            if (err1 && done1) errd_n1++;
            if (err3 && done3) errd_n3++;
        end
    end

    task automatic check(input string tag, input logic [CB-1:0] got, input logic [CB-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [IW-1:0] av, input logic [IW-1:0] bv);
        for (int i = 0; i < 16; i++) begin
            amem[i] = {(AB/IW){av}};
            bmem[i] = {(AB/IW){bv}};
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++)
            for (int w = 0; w < AB/32; w++) begin
                amem[i][w*32 +: 32] = $urandom;
                bmem[i][w*32 +: 32] = $urandom;
            end
    endtask

    function automatic logic [CB-1:0] gold(input int mt, input int nt, input int ktn,
                                           input int ntn, input bit s);
        logic [CB-1:0] r;
        logic [AB-1:0] at, bt;
        logic [IW-1:0] ae, be;
        int acc, av, bv;
        r = '0;
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++) begin
                acc = 0;
                for (int kt = 0; kt < ktn; kt++) begin
                    at = amem[mt*ktn + kt];
                    bt = bmem[kt*ntn + nt];
                    for (int k = 0; k < K; k++) begin
                        ae = at[(m*K + k)*IW +: IW];
                        be = bt[(n*K + k)*IW +: IW];
                        av = s ? int'($signed(ae)) : int'(ae);
                        bv = s ? int'($signed(be)) : int'(be);
                        acc += av * bv;
                    end
                end
                r[(m*N + n)*OW +: OW] = acc;
            end
        return r;
    endfunction

    task automatic clear_job(input int ktn);
        wa1.delete(); wa3.delete(); wd1.delete(); wd3.delete(); rlog.delete();
        rd_n1 = 0; rd_n3 = 0; done_n1 = 0; done_n3 = 0; errd_n1 = 0; errd_n3 = 0; err_n1 = 0;
        done_cyc1 = 0; wr_cyc1 = 0; last_iss = 0; last_acc = 0; max_out = 0; stall_n = 0;
        stable_bad = 1'b0; hold_v = 1'b0; kt_exp = ktn;
    endtask

    // Start a job, scramble the size inputs after start, wait for both engines.
    task automatic run_job(input int ms, input int ks, input int ns, input logic s,
                           input int hold, output int start_c);
        int t, hc;
        clear_job(ks / K);
        c_ready = (hold == 0);
        @(posedge clk); #1;
        m_size = SW'(ms); k_size = SW'(ks); n_size = SW'(ns); sgn = s; start = 1'b1;
        start_c = cyc;
        @(posedge clk); #1;
        start = 1'b0; m_size = '0; k_size = 8'd3; n_size = 8'd5; sgn = ~s;
        t = 0; hc = 0;
        while (t < 3000 && !(done_n1 > 0 && done_n3 > 0)) begin
            @(posedge clk); #1;
            t++;
            if (hold > 0 && we1 && !c_ready) begin
                hc++;
                if (hc > hold) c_ready = 1'b1;
            end
        end
        if (t >= 3000) check("timeout", CB'(0), CB'(1));
        c_ready = 1'b1;
    endtask

    task automatic check_const(input string tag, input logic [CB-1:0] exp);
        check({tag, "_n1"}, CB'(wd1.size()), CB'(1));
        check({tag, "_n3"}, CB'(wd3.size()), CB'(1));
        if (wd1.size() > 0) begin
            check({tag, "_addr1"}, CB'(wa1[0]), CB'(0));
            check({tag, "_data1"}, wd1[0], exp);
        end
        if (wd3.size() > 0) check({tag, "_data3"}, wd3[0], exp);
    endtask

    task automatic check_rand(input string tag, input bit s);
        check({tag, "_n1"}, CB'(wd1.size()), CB'(4));
        check({tag, "_n3"}, CB'(wd3.size()), CB'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < wd1.size()) begin
                check({tag, "_addr1"}, CB'(wa1[i]), CB'(i));
                check({tag, "_data1"}, wd1[i], gold(i / 2, i % 2, 3, 2, s));
            end
            if (i < wd3.size()) check({tag, "_data3"}, wd3[i], gold(i / 2, i % 2, 3, 2, s));
        end
    endtask

    initial begin
        int sc;
        kt_exp = 0;
        clear_job(1);
        #2 rst = 1'b1;
        #2;
        check("rst_ctl1", CB'({a_addr1, b_addr1, c_addr1, rd1, we1, busy1, done1, err1}), CB'(0));
        check("rst_data1", c_wd1, CB'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 4x4x4 unsigned, A=1 B=2: one tile, each element 4*1*2
        fill(8'h01, 8'h02);
        run_job(4, 4, 4, 1'b0, 0, sc);
        check_const("j1", {16{32'd8}});
        check("j1_reads", CB'(rd_n1), CB'(1));
        check("j1_done_after_wr", CB'(done_cyc1 - wr_cyc1), CB'(1));
        check("j1_busy_idle", CB'(busy1), CB'(0));

        // 8x8x12 random: Mt=2 Kt=3 Nt=2
        fill_rand();
        run_job(8, 12, 8, 1'b0, 0, sc);
        check_rand("j2", 1'b0);
        check("j2_reads", CB'(rlog.size()), CB'(12));
        for (int i = 0; i < 12; i++)
            if (i < rlog.size())
                check("j2_rd_addr", CB'(rlog[i]), CB'({AW'(exp_a[i]), AW'(exp_b[i])}));

        // same job, C ready held low 6 cycles on the first write
        run_job(8, 12, 8, 1'b0, 6, sc);
        check_rand("j3", 1'b0);
        check("j3_stall_cycles", CB'(stall_n), CB'(6));
        check("j3_c_stable", CB'(stable_bad), CB'(0));
        check("j3_outstanding_le1", CB'(max_out <= 1), CB'(1));

        // 4x4x16, A=1 B=3: four K beats, each element 16*3
        fill(8'h01, 8'h03);
        run_job(4, 16, 4, 1'b0, 0, sc);
        check_const("j4", {16{32'd48}});
        check("j4_reads3", CB'(rd_n3), CB'(4));

        // A=0xFF B=0x01: signed -> -4, unsigned -> 1020
        fill(8'hFF, 8'h01);
        run_job(4, 4, 4, 1'b1, 0, sc);
        check_const("j5s", {16{32'hFFFF_FFFC}});
        run_job(4, 4, 4, 1'b0, 0, sc);
        check_const("j5u", {16{32'd1020}});

        // illegal sizes
        run_job(6, 4, 4, 1'b0, 0, sc);
        check("e1_errdone", CB'(errd_n1), CB'(1));
        check("e1_err_total", CB'(err_n1), CB'(1));
        check("e1_latency", CB'(done_cyc1 - sc), CB'(2));
        check("e1_no_io", CB'(rd_n1 + wd1.size()), CB'(0));
        check("e1_errdone3", CB'(errd_n3), CB'(1));
        run_job(4, 0, 4, 1'b0, 0, sc);
        check("e2_errdone", CB'(errd_n1), CB'(1));
        check("e2_latency", CB'(done_cyc1 - sc), CB'(2));
        check("e2_no_io", CB'(rd_n1 + wd1.size()), CB'(0));

        // reset in the middle of a valid job
        fill_rand();
        clear_job(3);
        @(posedge clk); #1;
        m_size = 8'd8; k_size = 8'd12; n_size = 8'd8; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_ctl1", CB'({a_addr1, b_addr1, c_addr1, rd1, we1, busy1, done1, err1}), CB'(0));
        check("mid_rst_data1", c_wd1, CB'(0));
        check("mid_rst_ctl3", CB'({a_addr3, b_addr3, c_addr3, rd3, we3, busy3, done3, err3}), CB'(0));
        @(posedge clk); #1 rst = 1'b0;
        fill(8'h01, 8'h02);
        run_job(4, 4, 4, 1'b0, 0, sc);
        check_const("post_rst", {16{32'd8}});
        check("post_rst_err", CB'(err_n1), CB'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
